find_branch_seq: RTL and testbench
==================================

Name: find_branch_seq

Overview:
Sequential, parametrised successor to the combinational 16-bit find-first-set encoder. It accepts a WIDTH-bit branch mask over a valid/ready handshake. It then emits the index of every set bit, one per cycle, lowest index first, over a valid/ready output stream. It sits between the branch-condition collector and the branch dispatch logic, which consumes one target index per beat.

Parameters:
WIDTH, 64, mask width; must be a power of two and at least 2.
IDX_W, $clog2(WIDTH), index width; derived, must not be overridden.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_mask is valid
in_ready  output  1  block can accept a mask this cycle
in_mask  input  WIDTH  branch mask; bit i set means branch i is taken
out_valid  output  1  out_index, out_last and out_none are valid
out_ready  input  1  consumer accepts the current beat
out_index  output  IDX_W  index of the current set bit
out_last  output  1  current beat is the final beat for this mask
out_none  output  1  accepted mask was all-zero (index field is a sentinel)
busy  output  1  high while a mask is being scanned (equals out_valid)

Behaviour:
- Internal state:
  - pending register, WIDTH bits: set bits not yet emitted.
  - Registered outputs: out_valid, out_index, out_last, out_none.
- Reset (rst=1 at a clk edge), regardless of state:
  - out_valid=0, out_index=all ones, out_last=0, out_none=0, pending=0.
  - Any scan in progress is dropped; no further beats for that mask.
- in_ready = ~out_valid | (out_valid & out_last & out_ready). This is combinational from out_ready and allows back-to-back masks with no bubble.
- Input accept (in_valid & in_ready), with f = index of the lowest set bit of in_mask:
  - Nonzero mask, next cycle: out_valid=1, out_index=f, pending=in_mask with bit f cleared, out_last=(pending==0), out_none=0.
  - Zero mask, next cycle: out_valid=1, out_index=all ones, out_last=1, out_none=1, pending=0. This keeps the original sentinel; out_none disambiguates it from a real index WIDTH-1.
  - Latency from accept to first beat: 1 cycle.
- Output handshake (out_valid & out_ready):
  - If out_last=1: out_valid falls next cycle, unless a new mask is accepted in the same cycle, in which case the new mask's first beat loads instead.
  - If out_last=0: next cycle out_index = lowest set bit of pending, that bit is cleared, and out_last = (remaining pending == 0).
  - Throughput: 1 index per cycle.
- Stall (out_valid & ~out_ready): out_index, out_last, out_none and pending hold stable; in_ready=0.
- Beat count: a mask with k set bits yields exactly k beats (k>=1), or exactly 1 beat if the mask is zero.
- in_mask is sampled only on accept. Changes on in_mask at other times have no effect.
- Find-first logic is a log2(WIDTH)-level halving tree:
  - Each level tests whether the lower half is all-zero and selects a half.
  - The selection bit at each level forms the corresponding index bit, MSB level first.
  - There are no loops over WIDTH with early exit.

Optional Feature:
FIND_BRANCH_MSB_FIRST_EN:
- Defined: scan order is reversed. Every "lowest set bit" above becomes "highest set bit"; the tree tests the upper half first. The zero-mask sentinel (all ones, out_none=1) is unchanged.
- Undefined: LSB-first order as specified above.
- Port list and timing are identical in both builds.

Test Plan:
1. WIDTH=16, rst 2 cycles -> out_valid=0, out_index=4'hF, out_last=0, out_none=0, in_ready=1.
2. in_mask=16'h8421, out_ready=1 -> out_index 0,5,10,15 on 4 consecutive cycles starting 1 cycle after accept; out_last=1 only on 15; in_ready low during beats 0-10.
3. in_mask=16'h0000 -> single beat: out_index=4'hF, out_none=1, out_last=1; out_valid=0 the following cycle.
4. in_mask=16'h0006, out_ready=0 for 3 cycles -> out_index=1 held stable with out_valid=1 and in_ready=0; then out_ready=1 -> beats 1, 2, out_last on 2.
5. in_mask=16'h0001 then 16'h0100 offered back-to-back, out_ready=1 -> in_ready=1 during the last beat of the first mask; out_index 0 then 8 in adjacent cycles with no bubble.
6. in_mask=16'hFFFF, rst asserted after 3 beats (0,1,2) -> out_valid=0 next cycle, in_ready=1, no beat 3 ever emitted. With FIND_BRANCH_MSB_FIRST_EN defined, 16'h8421 yields 15,10,5,0.

Source files
------------

// File: rtl/find_branch_seq.sv
// -----------------------------------------------------------------------------
// find_branch_seq
//
// Sequential find-first-set encoder. It accepts a WIDTH-bit branch mask over a
// valid/ready handshake. It then emits the index of every set bit, one per
// cycle, as a valid/ready stream. The default order is lowest index first.
//
// Build option:
//   FIND_BRANCH_MSB_FIRST_EN  - when defined, indices are emitted highest
//                               first. Ports and timing do not change.
//
// Parameters:
//   WIDTH  mask width (power of two, >= 2)
//   IDX_W  index width, derived from WIDTH (do not override)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in_mask is valid
//   in_ready   block can take a mask this cycle (combinational from out_ready)
//   in_mask    branch mask, bit i set = branch i taken
//   out_valid  out_index / out_last / out_none are valid
//   out_ready  consumer accepts the current beat
//   out_index  index of the current set bit (all ones for a zero mask)
//   out_last   final beat for this mask
//   out_none   accepted mask was all-zero
//   busy       scan in progress (same as out_valid)
// -----------------------------------------------------------------------------
module find_branch_seq #(
  parameter int WIDTH = 64,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             out_none,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Halving tree: each level looks at the current window and picks one half.
  // The pick at each level is one index bit, MSB level first. In LSB-first
  // order an all-zero vector naturally resolves to all ones.
  function automatic logic [IDX_W-1:0] find_first(input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] lomask;
    logic [IDX_W-1:0] idx;
    v   = m;
    idx = '0;
    for (int lvl = IDX_W - 1; lvl >= 0; lvl--) begin
      lomask = {WIDTH{1'b1}} >> (WIDTH - (1 << lvl));
`ifdef FIND_BRANCH_MSB_FIRST_EN
      if (((v >> (1 << lvl)) & lomask) != '0) begin
        idx[lvl] = 1'b1;
        v        = v >> (1 << lvl);
      end else begin
        idx[lvl] = 1'b0;
        v        = v & lomask;
      end
`else
      // Bits above the window are never tested, so they need not be masked.
      if ((v & lomask) == '0) begin
        idx[lvl] = 1'b1;
        v        = v >> (1 << lvl);
      end else begin
        idx[lvl] = 1'b0;
      end
`endif
    end
    return idx;
  endfunction

  logic [WIDTH-1:0] pending_p1;
  logic             accept;
  logic             advance;
  logic [WIDTH-1:0] src_p0;
  logic [IDX_W-1:0] first_p0;
  logic [WIDTH-1:0] rest_p0;

  // A new mask can only be taken while the last beat of the current one
  // leaves, so accept and advance are mutually exclusive.
  assign in_ready = ~out_valid | (out_last & out_ready);
  assign accept   = in_valid & in_ready;
  assign advance  = out_valid & out_ready & ~out_last;
  assign busy     = out_valid;

  // ---- stage p0: select scan source and find its next bit ----
  assign src_p0   = accept ? in_mask : pending_p1;
  assign first_p0 = find_first(src_p0);
  assign rest_p0  = src_p0 & ~(ONE << first_p0);

  // ---- stage p1: registered beat and remaining bits ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_index  <= '1;
      out_last   <= 1'b0;
      out_none   <= 1'b0;
      pending_p1 <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      if (in_mask == '0) begin
        out_index  <= '1;
        out_last   <= 1'b1;
        out_none   <= 1'b1;
        pending_p1 <= '0;
      end else begin
        out_index  <= first_p0;
        out_last   <= (rest_p0 == '0);
        out_none   <= 1'b0;
        pending_p1 <= rest_p0;
      end
    end else if (advance) begin
      out_index  <= first_p0;
      out_last   <= (rest_p0 == '0);
      pending_p1 <= rest_p0;
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_find_branch_seq.sv
module tb_find_branch_seq;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_mask;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_index;
  logic          out_last;
  logic          out_none;
  logic          busy;

  find_branch_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_last(out_last), .out_none(out_none),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   idx;
    logic last;
    logic none;
  } beat_t;

  typedef struct {
    logic [W-1:0] mask;
    int           lo;
    int           hi;
    int           n;
    logic         none;
  } vec_t;

  beat_t q[$];
  int    total = 0;
  int    bad   = 0;

  // values sampled in the most recent cycle
  logic s_valid, s_last, s_none, s_in_ready;
  int   s_index;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // Reference: list every set bit in scan order; zero mask is one sentinel beat.
  task automatic push_beats(input logic [W-1:0] m);
    int idxs[$];
    beat_t b;
    if (m == '0) begin
      b.idx = W - 1; b.last = 1'b1; b.none = 1'b1;
      q.push_back(b);
    end else begin
`ifdef FIND_BRANCH_MSB_FIRST_EN
      for (int i = W - 1; i >= 0; i--) if (m[i]) idxs.push_back(i);
`else
      for (int i = 0; i < W; i++) if (m[i]) idxs.push_back(i);
`endif
      foreach (idxs[k]) begin
        b.idx  = idxs[k];
        b.last = (k == idxs.size() - 1);
        b.none = 1'b0;
        q.push_back(b);
      end
    end
  endtask

  // One clock cycle: drive, sample on the falling edge, check against the
  // model, then update the model with the handshakes that happen at the edge.
  task automatic cycle(input logic v, input logic [W-1:0] m, input logic r);
    logic exp_rdy;
    in_valid  = v;
    in_mask   = m;
    out_ready = r;
    @(negedge clk);
    s_valid = out_valid; s_index = out_index; s_last = out_last;
    s_none = out_none; s_in_ready = in_ready;
    exp_rdy = (q.size() == 0) || (q.size() == 1 && r);
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, exp_rdy);
    chk("busy", busy, out_valid);
    if (out_valid && q.size() != 0) begin
      chk("out_index", out_index, q[0].idx);
      chk("out_last", out_last, q[0].last);
      chk("out_none", out_none, q[0].none);
    end
    if (q.size() != 0 && r) void'(q.pop_front());
    if (v && exp_rdy && !rst) push_beats(m);
    if (rst) q.delete();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[8];
  int   exp2[4];
  int   exp4[2];
  int   first, cnt, guard;
  logic fnone, done;

  initial begin
    tbl[0] = '{16'h0001, 0, 0, 1, 1'b0};
    tbl[1] = '{16'h8000, 15, 15, 1, 1'b0};
    tbl[2] = '{16'h0000, 15, 15, 1, 1'b1};
    tbl[3] = '{16'hFFFF, 0, 15, 16, 1'b0};
    tbl[4] = '{16'h0180, 7, 8, 2, 1'b0};
    tbl[5] = '{16'hA000, 13, 15, 2, 1'b0};
    tbl[6] = '{16'h0010, 4, 4, 1, 1'b0};
    tbl[7] = '{16'h5555, 0, 14, 8, 1'b0};
`ifdef FIND_BRANCH_MSB_FIRST_EN
    exp2 = '{15, 10, 5, 0};
    exp4 = '{2, 1};
`else
    exp2 = '{0, 5, 10, 15};
    exp4 = '{1, 2};
`endif

    // reset state
    rst = 1'b1; in_valid = 1'b0; in_mask = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_index", out_index, 15);
    chk("rst_last", out_last, 0);
    chk("rst_none", out_none, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // 8421 stream
    cycle(1'b1, 16'h8421, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, '0, 1'b1);
      chk("t2_valid", s_valid, 1);
      chk("t2_index", s_index, exp2[k]);
      chk("t2_last", s_last, k == 3);
      chk("t2_in_ready", s_in_ready, k == 3);
    end

    // zero mask
    cycle(1'b1, 16'h0000, 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("t3_index", s_index, 15);
    chk("t3_none", s_none, 1);
    chk("t3_last", s_last, 1);
    cycle(1'b0, '0, 1'b1);
    chk("t3_after", s_valid, 0);

    // stall
    cycle(1'b1, 16'h0006, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, '0, 1'b0);
      chk("t4_hold_idx", s_index, exp4[0]);
      chk("t4_hold_vld", s_valid, 1);
      chk("t4_hold_rdy", s_in_ready, 0);
    end
    cycle(1'b0, '0, 1'b1);
    chk("t4_b0", s_index, exp4[0]);
    chk("t4_b0_last", s_last, 0);
    cycle(1'b0, '0, 1'b1);
    chk("t4_b1", s_index, exp4[1]);
    chk("t4_b1_last", s_last, 1);

    // back-to-back masks
    cycle(1'b1, 16'h0001, 1'b1);
    cycle(1'b1, 16'h0100, 1'b1);
    chk("t5_idx0", s_index, 0);
    chk("t5_rdy_on_last", s_in_ready, 1);
    cycle(1'b0, '0, 1'b1);
    chk("t5_valid1", s_valid, 1);
    chk("t5_idx1", s_index, 8);
    cycle(1'b0, '0, 1'b1);

    // reset in the middle of a scan
    cycle(1'b1, 16'hFFFF, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    rst = 1'b1;
    cycle(1'b0, '0, 1'b1);
    rst = 1'b0;
    cycle(1'b0, '0, 1'b1);
    chk("t6_valid", s_valid, 0);
    chk("t6_in_ready", s_in_ready, 1);
    repeat (3) cycle(1'b0, '0, 1'b1);

    // table-driven single masks
    foreach (tbl[t]) begin
      cycle(1'b1, tbl[t].mask, 1'b1);
      cnt = 0; first = -1; fnone = 1'b0; done = 1'b0; guard = 0;
      while (!done && guard < 20) begin
        cycle(1'b0, '0, 1'b1);
        guard++;
        if (s_valid) begin
          if (cnt == 0) begin first = s_index; fnone = s_none; end
          cnt++;
          if (s_last) done = 1'b1;
        end
      end
      if (!done) chk("tbl_timeout", 0, 1);
`ifdef FIND_BRANCH_MSB_FIRST_EN
      chk("tbl_first", first, tbl[t].hi);
`else
      chk("tbl_first", first, tbl[t].lo);
`endif
      chk("tbl_count", cnt, tbl[t].n);
      chk("tbl_none", fnone, tbl[t].none);
    end

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] m;
      m = W'($urandom) & W'($urandom);
      if ($urandom_range(0, 9) == 0) m = '0;
      cycle($urandom_range(0, 1) == 1, m, $urandom_range(0, 9) < 7);
    end
    guard = 0;
    while (q.size() != 0 && guard < 40) begin
      cycle(1'b0, '0, 1'b1);
      guard++;
    end
    chk("drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
